// File: rtl/inst_cache.sv
// inst_cache: direct-mapped, read-only instruction cache sitting behind the PC
// stage. A hit returns the instruction one cycle later through registered
// outputs. A miss raises icache_busy in the same cycle and refills one line
// through a level request and ascending data beats.
//
// Ports:
//   clk, rst           clock and synchronous active-high reset
//   ce, pc             fetch enable and word-aligned fetch address from PC
//   flush              redirect; kills the delivery in flight
//   stall              global stall; freezes inst/inst_pc/inst_valid
//   icache_busy        miss or refill in progress, to the Staller
//   inst, inst_pc      registered instruction and its address, to the Decoder
//   inst_valid         inst/inst_pc carry a live fetch this cycle
//   mem_req, mem_addr  refill request (level) and line base address
//   mem_rdata          refill data beat
//   mem_rvalid         beat strobe; beats arrive in ascending word order
//
// state       | meaning
// ------------+---------------------------------------------------------
// S_IDLE      | lookup on pc; a miss latches the line base, goes to S_REFILL
// S_REFILL    | mem_req high; each beat writes one word of the line
// S_FILL_DONE | line installed; one busy cycle before lookups resume
module inst_cache #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_NUM   = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic [ADDR_W-1:0] pc,
    input  logic              flush,
    input  logic              stall,
    output logic              icache_busy,
    output logic [DATA_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_valid,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rvalid
);

    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(LINE_NUM);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W - 2;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_REFILL    = 2'd1;
    localparam logic [1:0] S_FILL_DONE = 2'd2;

    logic [1:0]          state;
    logic [OFF_W-1:0]    cnt;
    logic [LINE_NUM-1:0] valid;
    logic [TAG_W-1:0]    tag_mem  [LINE_NUM];
    logic [DATA_W-1:0]   data_mem [LINE_NUM*LINE_WORDS];

    logic [OFF_W-1:0] pc_off;
    logic [IDX_W-1:0] pc_idx;
    logic [TAG_W-1:0] pc_tag;
    logic [IDX_W-1:0] fill_idx;
    logic [TAG_W-1:0] fill_tag;
    logic             hit;
    logic             start_refill;
    logic             beat;
    logic             last_beat;

    assign pc_off = pc[OFF_W+1:2];
    assign pc_idx = pc[IDX_W+OFF_W+1:OFF_W+2];
    assign pc_tag = pc[ADDR_W-1:IDX_W+OFF_W+2];

    // The refill target comes from the latched line base, so the line being
    // written never depends on pc after the miss was taken.
    assign fill_idx = mem_addr[IDX_W+OFF_W+1:OFF_W+2];
    assign fill_tag = mem_addr[ADDR_W-1:IDX_W+OFF_W+2];

    assign hit          = ce && valid[pc_idx] && (tag_mem[pc_idx] == pc_tag);
    assign start_refill = (state == S_IDLE) && ce && !hit && !flush && !rst;
    assign beat         = (state == S_REFILL) && mem_rvalid && !rst;
    assign last_beat    = (cnt == OFF_W'(LINE_WORDS - 1));

    // Busy rises combinationally on the miss so PC holds pc in that same cycle.
    assign icache_busy = start_refill || (state != S_IDLE);
    assign mem_req     = (state == S_REFILL);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            valid    <= '0;
            mem_addr <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_refill) begin
                        state    <= S_REFILL;
                        cnt      <= '0;
                        mem_addr <= {pc_tag, pc_idx, {(OFF_W+2){1'b0}}};
                        // Drop the old line now so a half-written line can never hit.
                        valid[pc_idx] <= 1'b0;
                    end
                end
                S_REFILL: begin
                    if (mem_rvalid) begin
                        cnt <= cnt + OFF_W'(1);
                        if (last_beat) begin
                            valid[fill_idx] <= 1'b1;
                            state           <= S_FILL_DONE;
                        end
                    end
                end
                S_FILL_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Storage arrays carry no reset; the valid bits alone qualify their content.
    always_ff @(posedge clk) begin
        if (beat) begin
            data_mem[{fill_idx, cnt}] <= mem_rdata;
            if (last_beat) begin
                tag_mem[fill_idx] <= fill_tag;
            end
        end
    end

    // Flush outranks stall; a busy cycle never produces a valid delivery.
    always_ff @(posedge clk) begin
        if (rst) begin
            inst       <= '0;
            inst_pc    <= '0;
            inst_valid <= 1'b0;
        end else if (flush || icache_busy) begin
            inst_valid <= 1'b0;
        end else if (!stall) begin
            if ((state == S_IDLE) && hit) begin
                inst       <= data_mem[{pc_idx, pc_off}];
                inst_pc    <= pc;
                inst_valid <= 1'b1;
            end else begin
                inst_valid <= 1'b0;
            end
        end
    end

endmodule
